// File: rtl/processador_pkg.sv
// Shared constants for the multicycle core: opcodes, step encodings, ALU codes.
// Latency/backpressure: not applicable (package only).
package processador_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] ULA_ADD = 3'd0;
  localparam logic [2:0] ULA_SUB = 3'd1;
  localparam logic [2:0] ULA_AND = 3'd2;
  localparam logic [2:0] ULA_SLT = 3'd3;
  localparam logic [2:0] ULA_SLL = 3'd4;

  function automatic logic [2:0] ula_op_of(input logic [2:0] opcode);
    case (opcode)
      OP_SUB:  return ULA_SUB;
      OP_AND:  return ULA_AND;
      OP_SLT:  return ULA_SLT;
      OP_SLL:  return ULA_SLL;
      default: return ULA_ADD;
    endcase
  endfunction

  function automatic logic is_single_step(input logic [2:0] opcode);
    return (opcode == OP_MV) || (opcode == OP_MVI) || (opcode == OP_MVNZ);
  endfunction

endpackage

// File: rtl/ula_param.sv
// Combinational ALU y = a op b, modulo 2^DATA_W; zero latency.
// Backpressure: none, purely combinational.
module ula_param
  import processador_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ULA_ADD: y = a + b;
      ULA_SUB: y = a - b;
      ULA_AND: y = a & b;
      ULA_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ULA_SLL: y = a << b[SHAMT_W-1:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/processador_multiciclo_param.sv
// Multicycle core, T0-T3 step counter: mv/mvi/mvnz Done 1 cycle after fetch, ALU ops 3 cycles after.
// Backpressure: none; Run is sampled only in T0, a held Run fetches right after Done.
module processador_multiciclo_param
  import processador_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Run,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires
);

  if (DATA_W < 9) begin : g_bad_width
    $error("processador_multiciclo_param: DATA_W must be at least 9");
  end

  logic [1:0]        tstep_q, tstep_d;
  logic [8:0]        ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [DATA_W-1:0] rf [8];
  logic [DATA_W-1:0] ula_y;

  logic [7:0] rin, rout;
  logic       ir_in, a_in, g_in, din_out, g_out, done;

  logic [2:0] opcode, rx, ry;
  assign opcode = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];

  always_comb begin
    tstep_d = tstep_q;
    ir_in   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    din_out = 1'b0;
    g_out   = 1'b0;
    done    = 1'b0;
    rin     = '0;
    rout    = '0;
    case (tstep_q)
      T0: begin
        if (Run) begin
          ir_in   = 1'b1;
          tstep_d = T1;
        end
      end
      T1: begin
        if (is_single_step(opcode)) begin
          if (opcode == OP_MVI) din_out = 1'b1;
          else                  rout[ry] = 1'b1;
          rin[rx] = (opcode != OP_MVNZ) || (g_q != '0);
          done    = 1'b1;
          tstep_d = T0;
        end else begin
          rout[rx] = 1'b1;
          a_in     = 1'b1;
          tstep_d  = T2;
        end
      end
      T2: begin
        rout[ry] = 1'b1;
        g_in     = 1'b1;
        tstep_d  = T3;
      end
      T3: begin
        g_out   = 1'b1;
        rin[rx] = 1'b1;
        done    = 1'b1;
        tstep_d = T0;
      end
    endcase
    // Reset silences every source and sink so nothing leaks onto the bus or Done.
    if (Reset) begin
      ir_in   = 1'b0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      din_out = 1'b0;
      g_out   = 1'b0;
      done    = 1'b0;
      rin     = '0;
      rout    = '0;
    end
  end

  always_comb begin
    BusWires = '0;
    if (din_out) begin
      BusWires = DIN;
    end else if (g_out) begin
      BusWires = g_q;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (rout[i]) BusWires = rf[i];
      end
    end
  end

  assign Done = done;

  ula_param #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_ula (
    .op (ula_op_of(opcode)),
    .a  (a_q),
    .b  (BusWires),
    .y  (ula_y)
  );

  always_comb begin
    ir_d = ir_in ? DIN[8:0] : ir_q;
    a_d  = a_in  ? BusWires : a_q;
    g_d  = g_in  ? ula_y    : g_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tstep_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
    end else begin
      tstep_q <= tstep_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_reg
    logic [DATA_W-1:0] reg_q, reg_d;

    always_comb reg_d = rin[i] ? BusWires : reg_q;

    always_ff @(posedge Clock) begin
      if (Reset) reg_q <= '0;
      else       reg_q <= reg_d;
    end

    assign rf[i] = reg_q;
  end

endmodule

// File: tb/tb_processador_multiciclo_param.sv
// Drives a 16-bit and a 32-bit core with the same instruction stream; a scoreboard
// checks the bus value and the cycle of every Done against a reference model.
module tb_processador_multiciclo_param;
  import processador_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] din16 = '0;
  logic [31:0] din32 = '0;
  logic        done16, done32;
  logic [15:0] bus16;
  logic [31:0] bus32;

  always #5 clk = ~clk;

  processador_multiciclo_param #(.DATA_W(16)) dut16 (
    .Clock(clk), .Reset(reset), .DIN(din16), .Run(run), .Done(done16), .BusWires(bus16)
  );
  processador_multiciclo_param #(.DATA_W(32)) dut32 (
    .Clock(clk), .Reset(reset), .DIN(din32), .Run(run), .Done(done32), .BusWires(bus32)
  );

  typedef struct {
    logic [63:0] val;
    int          cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  exp_t e16, e32;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] mr [2][8];
  logic [63:0] mg [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int width_of(input int d);
    return (d == 0) ? 16 : 32;
  endfunction

  function automatic logic [63:0] ref_alu(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
    logic [63:0] mask;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a) - ((a >> (w - 1)) & 64'd1 ? (longint'(1) << w) : 0);
    sb = longint'(b) - ((b >> (w - 1)) & 64'd1 ? (longint'(1) << w) : 0);
    case (op)
      OP_ADD:  return (a + b) & mask;
      OP_SUB:  return (a - b) & mask;
      OP_AND:  return a & b;
      OP_SLT:  return (sa < sb) ? 64'd1 : 64'd0;
      OP_SLL:  return (a << (b % 64'(w))) & mask;
      default: return 64'd0;
    endcase
  endfunction

  // Returns the value the bus must carry in the Done cycle; updates the model state.
  function automatic logic [63:0] model_exec(input int d, input logic [2:0] op, input logic [2:0] x,
                                             input logic [2:0] y, input logic [63:0] imm);
    logic [63:0] v;
    int          w;
    w = width_of(d);
    case (op)
      OP_MV:   begin v = mr[d][y]; mr[d][x] = v; end
      OP_MVI:  begin v = imm & ((64'd1 << w) - 64'd1); mr[d][x] = v; end
      OP_MVNZ: begin v = mr[d][y]; if (mg[d] != 0) mr[d][x] = v; end
      default: begin v = ref_alu(op, mr[d][x], mr[d][y], w); mg[d] = v; mr[d][x] = v; end
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mg[d] = '0;
      for (int k = 0; k < 8; k++) mr[d][k] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL done16_unexpected: Done=1 at cycle %0d, expected no pending instruction", cyc);
      end else begin
        e16 = q16.pop_front();
        check("bus16_at_done", 64'(bus16), e16.val);
        check("done16_cycle", 64'(cyc), 64'(e16.cyc));
      end
    end
    if (done32) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL done32_unexpected: Done=1 at cycle %0d, expected no pending instruction", cyc);
      end else begin
        e32 = q32.pop_front();
        check("bus32_at_done", 64'(bus32), e32.val);
        check("done32_cycle", 64'(cyc), 64'(e32.cyc));
      end
    end
  end

  // Called #1 after a rising edge while both cores sit in T0.
  task automatic issue(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                       input logic [31:0] imm16, input logic [31:0] imm32);
    logic [31:0] r;
    int          lat;
    r = $urandom;
    din32 = {r[31:9], op, x, y};
    din16 = din32[15:0];
    run = 1'b1;
    @(posedge clk); #1;
    lat = is_single_step(op) ? 0 : 2;
    q16.push_back('{model_exec(0, op, x, y, 64'(imm16)), cyc + lat});
    q32.push_back('{model_exec(1, op, x, y, 64'(imm32)), cyc + lat});
    for (int i = 0; i <= lat; i++) begin
      r = $urandom;
      run = r[0];
      if (i == 0 && op == OP_MVI) begin
        din16 = imm16[15:0];
        din32 = imm32;
      end else begin
        din32 = $urandom;
        din16 = din32[15:0];
      end
      @(posedge clk); #1;
    end
    run = 1'b0;
  endtask

  task automatic rd(input logic [2:0] k);
    issue(OP_MV, k, k, 32'd0, 32'd0);
  endtask

  task automatic mvi(input logic [2:0] k, input logic [31:0] v16, input logic [31:0] v32);
    issue(OP_MVI, k, 3'd0, v16, v32);
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_done16"}, 64'(done16), 64'd0);
    check({nm, "_bus16"}, 64'(bus16), 64'd0);
    check({nm, "_done32"}, 64'(done32), 64'd0);
    check({nm, "_bus32"}, 64'(bus32), 64'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_quiet("in_reset");
      @(posedge clk);
    end
    #1 reset = 1'b0;

    repeat (10) begin
      din32 = $urandom;
      din16 = din32[15:0];
      @(negedge clk);
      check_quiet("idle_t0");
      @(posedge clk); #1;
    end
    for (int k = 0; k < 8; k++) rd(3'(k));

    mvi(3'd0, 32'h00A5, 32'h00A5);
    issue(OP_MV, 3'd1, 3'd0, 32'd0, 32'd0);
    rd(3'd0); rd(3'd1);

    mvi(3'd2, 32'hFFFF, 32'hFFFF_FFFF);
    mvi(3'd3, 32'h0002, 32'h0000_0001);
    issue(OP_ADD, 3'd2, 3'd3, 32'd0, 32'd0);
    issue(OP_SUB, 3'd3, 3'd2, 32'd0, 32'd0);
    rd(3'd2); rd(3'd3);

    mvi(3'd4, 32'h8000, 32'h8000_0000);
    mvi(3'd5, 32'h0001, 32'h0000_0001);
    issue(OP_SLT, 3'd4, 3'd5, 32'd0, 32'd0);
    mvi(3'd6, 32'd4, 32'd4);
    issue(OP_SLL, 3'd5, 3'd6, 32'd0, 32'd0);
    mvi(3'd7, 32'h00F0, 32'h00F0);
    issue(OP_AND, 3'd5, 3'd7, 32'd0, 32'd0);
    rd(3'd4); rd(3'd5);

    mvi(3'd1, 32'h1234, 32'h1234_5678);
    mvi(3'd0, 32'h0055, 32'h0055_0055);
    issue(OP_SUB, 3'd2, 3'd2, 32'd0, 32'd0);
    issue(OP_MVNZ, 3'd1, 3'd0, 32'd0, 32'd0);
    rd(3'd1);
    mvi(3'd2, 32'd1, 32'd1);
    mvi(3'd3, 32'd2, 32'd2);
    issue(OP_ADD, 3'd2, 3'd3, 32'd0, 32'd0);
    issue(OP_MVNZ, 3'd1, 3'd0, 32'd0, 32'd0);
    rd(3'd1);

    mvi(3'd6, 32'h4321, 32'h8765_4321);
    issue(OP_ADD, 3'd6, 3'd6, 32'd0, 32'd0);
    issue(OP_SLT, 3'd6, 3'd6, 32'd0, 32'd0);
    mvi(3'd7, 32'h0F0F, 32'h0F0F_0F0F);
    issue(OP_SUB, 3'd7, 3'd7, 32'd0, 32'd0);
    rd(3'd6); rd(3'd7);

    // Abort an add in T2: nothing may be written and all state must clear.
    din32 = {23'd0, OP_ADD, 3'd4, 3'd5};
    din16 = din32[15:0];
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_quiet("abort_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) rd(3'(k));
    issue(OP_MVNZ, 3'd1, 3'd0, 32'd0, 32'd0);
    mvi(3'd0, 32'h00A5, 32'hFFFF_FFFF);
    mvi(3'd1, 32'h0001, 32'h0000_0001);
    issue(OP_ADD, 3'd0, 3'd1, 32'd0, 32'd0);
    rd(3'd0);

    repeat (300) begin
      if ($urandom_range(0, 4) == 0) begin
        din32 = $urandom;
        din16 = din32[15:0];
        @(posedge clk); #1;
      end
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            $urandom, $urandom);
    end
    for (int k = 0; k < 8; k++) rd(3'(k));

    repeat (3) @(posedge clk);
    #1;
    check("pending16_at_end", 64'(q16.size()), 64'd0);
    check("pending32_at_end", 64'(q32.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
